// File: rtl/spike_time_decoder_pkg.sv
// Shared types and helpers for the spike time decoder and its gamma-aligned neighbours.
// Contents: tw_f() width helper, capture FSM state enum, result payload struct.
// Configuration macro: SPIKE_DECODER_PULSE_CHECK_EN adds the HIGH state used by pulse checking.
package spike_time_pkg;

  // Widest time field the result payload can carry; the gamma cycle must fit in it.
  localparam int unsigned TIME_W_MAX = 16;

  // Bits needed to count one gamma cycle.
  function automatic int unsigned tw_f(input int unsigned gamma_cycle_width);
    return $clog2(gamma_cycle_width);
  endfunction

`ifdef SPIKE_DECODER_PULSE_CHECK_EN
  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_HIGH  = 2'd1,
    ST_DONE  = 2'd2
  } cap_state_e;
`else
  typedef enum logic {
    ST_ARMED = 1'b0,
    ST_DONE  = 1'b1
  } cap_state_e;
`endif

  typedef struct packed {
    logic [TIME_W_MAX-1:0] time_val;
    logic                  none;
    logic                  malformed;
  } spike_result_t;

endpackage

// File: rtl/spike_time_decoder_if.sv
// Result channel of the spike time decoder (valid/ready handshake plus payload fields).
// master: drives out_valid, out_time, out_none, out_malformed; samples out_ready.
// slave : the consumer side.
interface spike_time_decoder_if #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 128
);
  localparam int unsigned TW = spike_time_pkg::tw_f(GAMMA_CYCLE_WIDTH);

  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_time;
  logic          out_none;
  logic          out_malformed;

  modport master (
    output out_valid, out_time, out_none, out_malformed,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_time, out_none, out_malformed,
    output out_ready
  );
endinterface

// File: rtl/spike_time_decoder_gamma_counter.sv
// gamma_counter: free-running gamma-cycle counter shared by encoder, delay and decoder stages.
// Ports: aclk, grst (async, active-high), cnt (0..G-1), gamma_tick (high while cnt == G-1).
module gamma_counter #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 128
) (
  input  logic                                           aclk,
  input  logic                                           grst,
  output logic [spike_time_pkg::tw_f(GAMMA_CYCLE_WIDTH)-1:0] cnt,
  output logic                                           gamma_tick
);
  localparam int unsigned TW = spike_time_pkg::tw_f(GAMMA_CYCLE_WIDTH);

  // Power-of-two length wraps naturally; tick is registered one cycle ahead of cnt == G-1.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      cnt        <= '0;
      gamma_tick <= 1'b0;
    end else begin
      cnt        <= cnt + TW'(1);
      gamma_tick <= (cnt == TW'(GAMMA_CYCLE_WIDTH - 2));
    end
  end
endmodule

// File: rtl/spike_time_decoder.sv
// spike_time_decoder: captures the first rising-edge time of spike_in within each gamma cycle
// and emits one result per cycle over a valid/ready channel.
// Ports: aclk, grst (async, active-high), spike_in, gamma_tick, overrun (sticky),
//        out_if (master: out_valid/out_ready/out_time/out_none/out_malformed).
// Macro SPIKE_DECODER_PULSE_CHECK_EN: compiles in pulse-width checking (HIGH state, width
// counter, out_malformed); without it out_malformed is 0.
module spike_time_decoder #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 128,
  parameter int unsigned PULSE_WIDTH       = 8
) (
  input  logic                   aclk,
  input  logic                   grst,
  input  logic                   spike_in,
  output logic                   gamma_tick,
  output logic                   overrun,
  spike_time_decoder_if.master   out_if
);
  import spike_time_pkg::*;

  localparam int unsigned TW = tw_f(GAMMA_CYCLE_WIDTH);

  // Elaboration-time parameter legality checks.
  if (GAMMA_CYCLE_WIDTH < 4 || (GAMMA_CYCLE_WIDTH & (GAMMA_CYCLE_WIDTH - 1)) != 0 ||
      GAMMA_CYCLE_WIDTH >= (32'd1 << TIME_W_MAX)) begin : g_bad_gamma
    $error("GAMMA_CYCLE_WIDTH must be a power of 2, at least 4 and below 2**TIME_W_MAX");
  end
  if (PULSE_WIDTH < 1 || PULSE_WIDTH >= GAMMA_CYCLE_WIDTH) begin : g_bad_pulse
    $error("PULSE_WIDTH must be at least 1 and less than GAMMA_CYCLE_WIDTH");
  end

  logic [TW-1:0] cnt;
  logic          spike_prev;
  logic          edge_c;
  cap_state_e    state, state_nxt;
  logic [TW-1:0] t_cap, t_cap_nxt;
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
  logic [TW-1:0] wcnt, wcnt_nxt;
  logic          bad, bad_nxt;
`endif
  spike_result_t res_q, res_c;
  logic          out_valid_q;
  logic          unused_c;

  gamma_counter #(.GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH)) u_gamma_counter (
    .aclk       (aclk),
    .grst       (grst),
    .cnt        (cnt),
    .gamma_tick (gamma_tick)
  );

  // Edge history is deliberately kept across gamma boundaries.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) spike_prev <= 1'b0;
    else      spike_prev <= spike_in;
  end

  assign edge_c = spike_in & ~spike_prev;

  // Capture FSM next state, plus the result as it stands after this cycle's evaluation.
  always_comb begin
    state_nxt = state;
    t_cap_nxt = t_cap;
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
    wcnt_nxt  = wcnt;
    bad_nxt   = bad;
`endif
    res_c     = '0;
    case (state)
      ST_ARMED: begin
        if (edge_c) begin
          t_cap_nxt = cnt;
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
          state_nxt = ST_HIGH;
          wcnt_nxt  = TW'(1);
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
      ST_HIGH: begin
        if (spike_in) begin
          if (wcnt != '1) wcnt_nxt = wcnt + TW'(1);
        end else begin
          state_nxt = ST_DONE;
          if (wcnt != TW'(PULSE_WIDTH)) bad_nxt = 1'b1;
        end
      end
      ST_DONE: begin
        if (edge_c) bad_nxt = 1'b1;
      end
`else
      ST_DONE: ;
`endif
      default: state_nxt = ST_ARMED;
    endcase

    res_c.none = (state_nxt == ST_ARMED);
    if (state_nxt != ST_ARMED) res_c.time_val = TIME_W_MAX'(t_cap_nxt);
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
    res_c.malformed = bad_nxt | (state_nxt == ST_HIGH);
`else
    res_c.malformed = 1'b0;
`endif
  end

  // Capture state register; every gamma boundary re-arms for the next cycle.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state <= ST_ARMED;
      t_cap <= '0;
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
      wcnt  <= '0;
      bad   <= 1'b0;
`endif
    end else if (gamma_tick) begin
      state <= ST_ARMED;
      t_cap <= '0;
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
      wcnt  <= '0;
      bad   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      t_cap <= t_cap_nxt;
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
      wcnt  <= wcnt_nxt;
      bad   <= bad_nxt;
`endif
    end
  end

  // Result holding register; a load over an unaccepted result marks overrun.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      res_q       <= '0;
      out_valid_q <= 1'b0;
      overrun     <= 1'b0;
    end else if (gamma_tick) begin
      res_q       <= res_c;
      out_valid_q <= 1'b1;
      if (out_valid_q && !out_if.out_ready) overrun <= 1'b1;
    end else if (out_if.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_if.out_valid     = out_valid_q;
  assign out_if.out_time      = res_q.time_val[TW-1:0];
  assign out_if.out_none      = res_q.none;
  assign out_if.out_malformed = res_q.malformed;

  // Upper payload bits stay zero for this gamma length.
  assign unused_c = ^res_q.time_val[TIME_W_MAX-1:TW];
endmodule

// File: tb/tb_spike_time_decoder.sv
// Self-checking bench for spike_time_decoder (G=128, PULSE_WIDTH=8); malformed expectations
// follow SPIKE_DECODER_PULSE_CHECK_EN.
module tb_spike_time_decoder;
  localparam int unsigned G  = 128;
  localparam int unsigned PW = 8;
`ifdef SPIKE_DECODER_PULSE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int s1; int w1; int s2; int w2;
    int e_time; bit e_none; bit e_mal;
  } vec_t;

  typedef struct {
    int t; bit none; bit mal;
  } exp_t;

  logic aclk = 1'b0;
  logic grst = 1'b1;
  logic spike_in = 1'b0;
  logic gamma_tick;
  logic overrun;

  spike_time_decoder_if #(.GAMMA_CYCLE_WIDTH(G)) out_if ();

  spike_time_decoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) dut (
    .aclk       (aclk),
    .grst       (grst),
    .spike_in   (spike_in),
    .gamma_tick (gamma_tick),
    .overrun    (overrun),
    .out_if     (out_if)
  );

  always #5 aclk = ~aclk;

  int   checks = 0;
  int   errors = 0;
  int   carry  = 0;
  exp_t sb[$];
  vec_t tbl[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit level(input int c, input int s1, input int w1, input int s2, input int w2);
    return (c < carry) || (s1 >= 0 && c >= s1 && c < s1 + w1) || (s2 >= 0 && c >= s2 && c < s2 + w2);
  endfunction

  // Drives cnt positions c_from..c_to; leaves time at #1 after the edge ending c_to.
  task automatic drive(input int s1, input int w1, input int s2, input int w2,
                       input int c_from, input int c_to, input bit chk_tick);
    for (int c = c_from; c <= c_to; c++) begin
      spike_in = level(c, s1, w1, s2, w2);
      if (chk_tick) check("gamma_tick", int'(gamma_tick), int'(c == G - 1));
      @(posedge aclk);
      #1;
    end
  endtask

  // Pulse tails running past the cycle end continue into the next cycle.
  task automatic update_carry(input int s1, input int w1, input int s2, input int w2);
    int e;
    e = 0;
    if (s1 >= 0 && s1 + w1 > G) e = s1 + w1 - G;
    if (s2 >= 0 && s2 + w2 - G > e) e = s2 + w2 - G;
    carry = e;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"},     int'(out_if.out_valid), 0);
    check({tag, "_time"},      int'(out_if.out_time), 0);
    check({tag, "_none"},      int'(out_if.out_none), 0);
    check({tag, "_malformed"}, int'(out_if.out_malformed), 0);
    check({tag, "_overrun"},   int'(overrun), 0);
    check({tag, "_tick"},      int'(gamma_tick), 0);
  endtask

  // Leaves the DUT just released from reset, in the cnt=0 cycle.
  task automatic do_reset();
    grst     = 1'b1;
    spike_in = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check_zero("reset");
    grst  = 1'b0;
    carry = 0;
  endtask

  task automatic count_to_tick(output int n, output bit saw_valid);
    n = 0;
    saw_valid = 1'b0;
    while (!gamma_tick && n < 300) begin
      if (out_if.out_valid) saw_valid = 1'b1;
      @(posedge aclk);
      #1;
      n++;
    end
  endtask

  initial begin
    int  n;
    bit  sv;
    exp_t e;

    tbl[0] = '{5,   8, -1, 0,   5,   1'b0, 1'b0};
    tbl[1] = '{-1,  0, -1, 0,   0,   1'b1, 1'b0};
    tbl[2] = '{0,   8, -1, 0,   0,   1'b0, 1'b0};
    tbl[3] = '{127, 8, -1, 0,   127, 1'b0, 1'b1};
    tbl[4] = '{-1,  0, -1, 0,   0,   1'b1, 1'b0};
    tbl[5] = '{10,  8, 40, 8,   10,  1'b0, 1'b1};
    tbl[6] = '{20,  7, -1, 0,   20,  1'b0, 1'b1};
    tbl[7] = '{119, 8, -1, 0,   119, 1'b0, 1'b0};
    tbl[8] = '{120, 8, -1, 0,   120, 1'b0, 1'b1};
    tbl[9] = '{126, 1, -1, 0,   126, 1'b0, 1'b1};

    out_if.out_ready = 1'b1;

    // First tick after release.
    do_reset();
    count_to_tick(n, sv);
    check("first_tick_delay", n, int'(G - 1));

    // Table-driven gamma cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{tbl[i].e_time, tbl[i].e_none, tbl[i].e_mal & CHK});
      drive(tbl[i].s1, tbl[i].w1, tbl[i].s2, tbl[i].w2, 0, int'(G) - 1, 1'b1);
      update_carry(tbl[i].s1, tbl[i].w1, tbl[i].s2, tbl[i].w2);
      e = sb.pop_front();
      check($sformatf("v%0d_valid", i),     int'(out_if.out_valid), 1);
      check($sformatf("v%0d_time", i),      int'(out_if.out_time), e.t);
      check($sformatf("v%0d_none", i),      int'(out_if.out_none), int'(e.none));
      check($sformatf("v%0d_malformed", i), int'(out_if.out_malformed), int'(e.mal));
    end
    @(posedge aclk);
    #1;
    check("valid_drop", int'(out_if.out_valid), 0);

    // Overrun: two results without accept.
    do_reset();
    out_if.out_ready = 1'b0;
    drive(5, 8, -1, 0, 0, int'(G) - 1, 1'b0);
    check("ovr_first_valid", int'(out_if.out_valid), 1);
    check("ovr_first_time",  int'(out_if.out_time), 5);
    check("ovr_first_flag",  int'(overrun), 0);
    drive(-1, 0, -1, 0, 0, 49, 1'b0);
    check("ovr_hold_valid", int'(out_if.out_valid), 1);
    check("ovr_hold_time",  int'(out_if.out_time), 5);
    drive(-1, 0, -1, 0, 50, int'(G) - 1, 1'b0);
    check("ovr_second_valid", int'(out_if.out_valid), 1);
    check("ovr_second_none",  int'(out_if.out_none), 1);
    check("ovr_second_time",  int'(out_if.out_time), 0);
    check("ovr_second_flag",  int'(overrun), 1);
    out_if.out_ready = 1'b1;
    @(posedge aclk);
    #1;
    check("ovr_accept_valid", int'(out_if.out_valid), 0);
    check("ovr_sticky1", int'(overrun), 1);
    drive(-1, 0, -1, 0, 1, int'(G) - 1, 1'b0);
    check("ovr_third_valid", int'(out_if.out_valid), 1);
    check("ovr_sticky2", int'(overrun), 1);

    // Reset mid-cycle after a captured edge.
    do_reset();
    drive(20, 8, -1, 0, 0, 59, 1'b0);
    grst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge aclk);
    #1;
    grst = 1'b0;
    count_to_tick(n, sv);
    check("midrst_tick_delay", n, int'(G - 1));
    check("midrst_no_result", int'(sv), 0);
    @(posedge aclk);
    #1;
    check("midrst_valid", int'(out_if.out_valid), 1);
    check("midrst_none",  int'(out_if.out_none), 1);
    check("midrst_time",  int'(out_if.out_time), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
